// File: rtl/fft_magnitude_engine.sv
// Framed re^2+im^2 engine: LANES bins per clock through a 2-stage multiply/add pipeline, frame held until out_ready.
// Optional FFT_MAG_PEAK_TRACK_EN adds peak_index/peak_mag (lowest bin wins ties).
module fft_magnitude_engine #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int BUFFER_SIZE  = 32,
  parameter int LANES        = 4,
  parameter int OUT_WIDTH    = 32,
  parameter int OUT_SHIFT    = 0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [BUFFER_SIZE*SAMPLE_WIDTH-1:0] in_real,
  input  logic [BUFFER_SIZE*SAMPLE_WIDTH-1:0] in_imag,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [BUFFER_SIZE*OUT_WIDTH-1:0]    out_mags,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_sat
`ifdef FFT_MAG_PEAK_TRACK_EN
  ,
  output logic [$clog2(BUFFER_SIZE)-1:0]      peak_index,
  output logic [OUT_WIDTH-1:0]                peak_mag
`endif
);

  localparam int PW = 2 * SAMPLE_WIDTH;
  localparam int SW = PW + 1;
  localparam int CW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

  if (BUFFER_SIZE % LANES != 0) begin : g_bad_lanes
    $error("fft_magnitude_engine: BUFFER_SIZE must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, DONE} state_t;

  state_t                              state;
  logic [BUFFER_SIZE*SAMPLE_WIDTH-1:0] fb_re;
  logic [BUFFER_SIZE*SAMPLE_WIDTH-1:0] fb_im;
  logic [CW-1:0]                       cnt;
  logic [CW-1:0]                       s1_bin;
  logic                                s1_vld;
  logic [PW-1:0]                       s1_re2 [LANES];
  logic [PW-1:0]                       s1_im2 [LANES];
  logic [PW-1:0]                       sq_re  [LANES];
  logic [PW-1:0]                       sq_im  [LANES];
  logic [OUT_WIDTH-1:0]                lane_mag_a [LANES];
  logic [LANES-1:0]                    lane_sat_v;
  logic                                last_issue;

  assign last_issue = (int'(cnt) + LANES >= BUFFER_SIZE);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [SAMPLE_WIDTH-1:0] re;
    logic signed [SAMPLE_WIDTH-1:0] im;
    logic signed [PW-1:0]           re_ext;
    logic signed [PW-1:0]           im_ext;
    logic [SW-1:0]                  sum;
    logic [SW+OUT_WIDTH-1:0]        shifted;

    assign re     = fb_re[(int'(cnt) + g)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign im     = fb_im[(int'(cnt) + g)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    // Squaring at full 2W precision keeps (-2^(W-1))^2 exact.
    assign re_ext = PW'(re);
    assign im_ext = PW'(im);
    assign sq_re[g] = re_ext * re_ext;
    assign sq_im[g] = im_ext * im_ext;

    assign sum     = {1'b0, s1_re2[g]} + {1'b0, s1_im2[g]};
    assign shifted = (SW+OUT_WIDTH)'(sum) >> OUT_SHIFT;
    assign lane_sat_v[g] = |(shifted >> OUT_WIDTH);
    assign lane_mag_a[g] = lane_sat_v[g] ? {OUT_WIDTH{1'b1}} : shifted[OUT_WIDTH-1:0];
  end

`ifdef FFT_MAG_PEAK_TRACK_EN
  localparam int IW = $clog2(BUFFER_SIZE);
  logic [OUT_WIDTH-1:0] pk_mag_n;
  logic [IW-1:0]        pk_idx_n;

  // Strict compare in ascending bin order keeps the lowest index on ties.
  always_comb begin
    pk_mag_n = peak_mag;
    pk_idx_n = peak_index;
    for (int l = 0; l < LANES; l++) begin
      if (lane_mag_a[l] > pk_mag_n) begin
        pk_mag_n = lane_mag_a[l];
        pk_idx_n = IW'(int'(s1_bin) + l);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_mags  <= '0;
      out_sat   <= 1'b0;
      fb_re     <= '0;
      fb_im     <= '0;
      cnt       <= '0;
      s1_bin    <= '0;
      s1_vld    <= 1'b0;
      s1_re2    <= '{default: '0};
      s1_im2    <= '{default: '0};
`ifdef FFT_MAG_PEAK_TRACK_EN
      peak_index <= '0;
      peak_mag   <= '0;
`endif
    end else begin
      s1_vld <= (state == COMPUTE);
      if (state == COMPUTE) begin
        s1_bin <= cnt;
        s1_re2 <= sq_re;
        s1_im2 <= sq_im;
      end

      if (s1_vld) begin
        for (int l = 0; l < LANES; l++) begin
          out_mags[(int'(s1_bin) + l)*OUT_WIDTH +: OUT_WIDTH] <= lane_mag_a[l];
        end
        if (|lane_sat_v) out_sat <= 1'b1;
`ifdef FFT_MAG_PEAK_TRACK_EN
        peak_index <= pk_idx_n;
        peak_mag   <= pk_mag_n;
`endif
      end

      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            fb_re    <= in_real;
            fb_im    <= in_imag;
            cnt      <= '0;
            out_sat  <= 1'b0;
            in_ready <= 1'b0;
            state    <= COMPUTE;
`ifdef FFT_MAG_PEAK_TRACK_EN
            peak_index <= '0;
            peak_mag   <= '0;
`endif
          end
        end
        COMPUTE: begin
          if (last_issue) begin
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + CW'(LANES);
          end
        end
        DRAIN: begin
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
